// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the alu_regfile sequencer: state encoding and the
// bit positions of the fixed 16-bit instruction field map.
package alu_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam int OP_MSB        = 15;
   localparam int OP_LSB        = 13;
   localparam int SRC1_IMM_BIT  = 12;
   localparam int SRC0_ZERO_BIT = 11;
   localparam int RD_MSB        = 10;
   localparam int RD_LSB        = 9;
   localparam int RS_MSB        = 8;
   localparam int RS_LSB        = 7;
   localparam int RT_MSB        = 1;
   localparam int RT_LSB        = 0;
   localparam int IMM_LSB       = 0;

   localparam int OP_W      = 3;
   localparam int REG_AW    = 2;
   localparam int DATA_W    = 8;
   localparam int IMM_EXT_W = 9;

endpackage

// File: rtl/alu_seq_ctrl_instr_decode.sv
// Combinational field extraction of the latched instruction word, including
// sign extension of the immediate to the ALU operand width.
module instr_decode
   import alu_seq_ctrl_pkg::*;
#(
   parameter int IMM_W = 7
) (
   input  logic [15:0]           instr,
   output logic [OP_W-1:0]       alu_op,
   output logic                  src1_imm,
   output logic                  src0_zero,
   output logic [REG_AW-1:0]     rd,
   output logic [REG_AW-1:0]     rs,
   output logic [REG_AW-1:0]     rt,
   output logic [IMM_EXT_W-1:0]  imm_ext
);

   logic [IMM_W-1:0] imm;

   assign alu_op    = instr[OP_MSB:OP_LSB];
   assign src1_imm  = instr[SRC1_IMM_BIT];
   assign src0_zero = instr[SRC0_ZERO_BIT];
   assign rd        = instr[RD_MSB:RD_LSB];
   assign rs        = instr[RS_MSB:RS_LSB];
   // rt shares its bits with the low end of the immediate field
   assign rt        = instr[RT_MSB:RT_LSB];
   assign imm       = instr[IMM_LSB +: IMM_W];
   assign imm_ext   = {{(IMM_EXT_W - IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer feeding alu_regfile: accepts one instruction, drives the
// read/ALU controls, captures the result and flags, then writes the result back.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | instr_ready high, waiting for instr_valid
//  READ  | register read; ALU controls driven from the latched word
//  EXEC  | controls held; result, zero and overflow captured at the edge
//  WB    | reg_write and done pulse; wr_addr/wr_data present the result
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int IMM_W   = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [7:0]         alu_result,
   input  logic               alu_ovf,
   input  logic               alu_zero,
   output logic [1:0]         rd0_addr,
   output logic [1:0]         rd1_addr,
   output logic [1:0]         wr_addr,
   output logic               reg_read,
   output logic               reg_write,
   output logic [8:0]         wr_data,
   output logic [8:0]         instr_i,
   output logic               alu_src0,
   output logic               alu_src1,
   output logic [2:0]         alu_op,
   output logic               done,
   output logic               ovf_sticky,
   output logic               zero_q
);

   state_t                 state;
   state_t                 state_nxt;
   logic [INSTR_W-1:0]     instr_q;
   logic [DATA_W-1:0]      res_q;
   logic [REG_AW-1:0]      wr_addr_q;
   logic                   zero_r;
   logic                   ovf_r;

   logic [OP_W-1:0]        dec_op;
   logic                   dec_src1_imm;
   logic                   dec_src0_zero;
   logic [REG_AW-1:0]      dec_rd;
   logic [REG_AW-1:0]      dec_rs;
   logic [REG_AW-1:0]      dec_rt;
   logic [IMM_EXT_W-1:0]   dec_imm;

   instr_decode #(
      .IMM_W (IMM_W)
   ) u_decode (
      .instr     (instr_q),
      .alu_op    (dec_op),
      .src1_imm  (dec_src1_imm),
      .src0_zero (dec_src0_zero),
      .rd        (dec_rd),
      .rs        (dec_rs),
      .rt        (dec_rt),
      .imm_ext   (dec_imm)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         instr_q   <= '0;
         res_q     <= '0;
         wr_addr_q <= '0;
         zero_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && instr_valid) begin
            instr_q <= instr;
         end
         if (state == ST_EXEC) begin
            res_q     <= alu_result;
            zero_r    <= alu_zero;
            ovf_r     <= ovf_r | alu_ovf;
            wr_addr_q <= dec_rd;
         end
      end
   end

   // reg_write/done decode straight from state so an async reset kills them at once
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      reg_read    = 1'b0;
      rd0_addr    = '0;
      rd1_addr    = '0;
      alu_src0    = 1'b0;
      alu_src1    = 1'b0;
      alu_op      = '0;
      instr_i     = '0;
      reg_write   = 1'b0;
      done        = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_nxt = ST_READ;
            end
         end
         ST_READ, ST_EXEC: begin
            reg_read  = 1'b1;
            rd0_addr  = dec_rs;
            rd1_addr  = dec_rt;
            alu_src0  = dec_src0_zero;
            alu_src1  = dec_src1_imm;
            alu_op    = dec_op;
            instr_i   = dec_imm;
            state_nxt = (state == ST_READ) ? ST_EXEC : ST_WB;
         end
         ST_WB: begin
            reg_write = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign wr_data    = {res_q[DATA_W-1], res_q};
   assign wr_addr    = wr_addr_q;
   assign zero_q     = zero_r;
   assign ovf_sticky = ovf_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: table of single-instruction vectors plus
// back-to-back issue and reset-during-write-back sequences.
module tb_alu_seq_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  alu_result;
   logic        alu_ovf;
   logic        alu_zero;
   logic [1:0]  rd0_addr;
   logic [1:0]  rd1_addr;
   logic [1:0]  wr_addr;
   logic        reg_read;
   logic        reg_write;
   logic [8:0]  wr_data;
   logic [8:0]  instr_i;
   logic        alu_src0;
   logic        alu_src1;
   logic [2:0]  alu_op;
   logic        done;
   logic        ovf_sticky;
   logic        zero_q;

   alu_seq_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_result  (alu_result),
      .alu_ovf     (alu_ovf),
      .alu_zero    (alu_zero),
      .rd0_addr    (rd0_addr),
      .rd1_addr    (rd1_addr),
      .wr_addr     (wr_addr),
      .reg_read    (reg_read),
      .reg_write   (reg_write),
      .wr_data     (wr_data),
      .instr_i     (instr_i),
      .alu_src0    (alu_src0),
      .alu_src1    (alu_src1),
      .alu_op      (alu_op),
      .done        (done),
      .ovf_sticky  (ovf_sticky),
      .zero_q      (zero_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  res;
      logic        ovf;
      logic        zero;
      logic [1:0]  e_rd0;
      logic [1:0]  e_rd1;
      logic [2:0]  e_op;
      logic        e_src0;
      logic        e_src1;
      logic [8:0]  e_imm;
      logic [1:0]  e_wa;
      logic [8:0]  e_wd;
      logic        e_zq;
      logic        e_ovs;
   } vec_t;

   vec_t vecs[5];
   int   n_checks;
   int   n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [2:0] op, input logic s1, input logic s0,
                                      input logic [1:0] rd, input logic [1:0] rs,
                                      input logic [6:0] imm);
      return {op, s1, s0, rd, rs, imm};
   endfunction

   initial begin
      logic [7:0]  rdy_bits;
      logic [7:0]  done_bits;
      logic [1:0]  wa_first;
      logic [1:0]  wa_second;
      logic [2:0]  op_b;
      logic [8:0]  imm_b;
      logic        rdy_s;
      logic        seen;
      int          acc;

      n_checks = 0;
      n_fail   = 0;

      //          instr                                 res    ovf   zero  rd0   rd1   op    s0    s1    imm      wa    wd       zq    ovs
      vecs[0] = '{mk(3'd0, 1'b0, 1'b0, 2'd2, 2'd1, 7'h03), 8'h85, 1'b0, 1'b0, 2'd1, 2'd3, 3'd0, 1'b0, 1'b0, 9'h003, 2'd2, 9'h185, 1'b0, 1'b0};
      vecs[1] = '{mk(3'd5, 1'b1, 1'b0, 2'd1, 2'd3, 7'h7F), 8'h7E, 1'b0, 1'b0, 2'd3, 2'd3, 3'd5, 1'b0, 1'b1, 9'h1FF, 2'd1, 9'h07E, 1'b0, 1'b0};
      vecs[2] = '{mk(3'd2, 1'b0, 1'b1, 2'd3, 2'd0, 7'h02), 8'h00, 1'b0, 1'b1, 2'd0, 2'd2, 3'd2, 1'b1, 1'b0, 9'h002, 2'd3, 9'h000, 1'b1, 1'b0};
      vecs[3] = '{mk(3'd7, 1'b1, 1'b1, 2'd0, 2'd2, 7'h40), 8'hC0, 1'b1, 1'b0, 2'd2, 2'd0, 3'd7, 1'b1, 1'b1, 9'h1C0, 2'd0, 9'h1C0, 1'b0, 1'b1};
      vecs[4] = '{mk(3'd1, 1'b0, 1'b0, 2'd1, 2'd1, 7'h3F), 8'h01, 1'b0, 1'b0, 2'd1, 2'd3, 3'd1, 1'b0, 1'b0, 9'h03F, 2'd1, 9'h001, 1'b0, 1'b1};

      rst         = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      alu_result  = '0;
      alu_ovf     = 1'b0;
      alu_zero    = 1'b0;

      #3;
      check("rst_ready", instr_ready, 1);
      check("rst_reg_read", reg_read, 0);
      check("rst_reg_write", reg_write, 0);
      check("rst_done", done, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_ovf_sticky", ovf_sticky, 0);
      check("rst_zero_q", zero_q, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         instr       = vecs[v].instr;
         instr_valid = 1'b1;
         check($sformatf("v%0d_idle_ready", v), instr_ready, 1);
         @(posedge clk);
         #1;
         instr_valid = 1'b0;
         instr       = 16'hFFFF;
         @(negedge clk);
         check($sformatf("v%0d_read_ready", v), instr_ready, 0);
         check($sformatf("v%0d_read_en", v), reg_read, 1);
         check($sformatf("v%0d_rd0", v), rd0_addr, vecs[v].e_rd0);
         check($sformatf("v%0d_rd1", v), rd1_addr, vecs[v].e_rd1);
         check($sformatf("v%0d_op", v), alu_op, vecs[v].e_op);
         check($sformatf("v%0d_src0", v), alu_src0, vecs[v].e_src0);
         check($sformatf("v%0d_src1", v), alu_src1, vecs[v].e_src1);
         check($sformatf("v%0d_instr_i", v), instr_i, vecs[v].e_imm);
         alu_result = vecs[v].res;
         alu_ovf    = vecs[v].ovf;
         alu_zero   = vecs[v].zero;
         @(negedge clk);
         check($sformatf("v%0d_exec_read_en", v), reg_read, 1);
         check($sformatf("v%0d_exec_op", v), alu_op, vecs[v].e_op);
         check($sformatf("v%0d_exec_instr_i", v), instr_i, vecs[v].e_imm);
         check($sformatf("v%0d_exec_write", v), reg_write, 0);
         @(negedge clk);
         check($sformatf("v%0d_wb_write", v), reg_write, 1);
         check($sformatf("v%0d_wb_done", v), done, 1);
         check($sformatf("v%0d_wb_read_en", v), reg_read, 0);
         check($sformatf("v%0d_wb_addr", v), wr_addr, vecs[v].e_wa);
         check($sformatf("v%0d_wb_data", v), wr_data, vecs[v].e_wd);
         alu_result = 8'hAA;
         alu_ovf    = 1'b0;
         alu_zero   = 1'b0;
         @(negedge clk);
         check($sformatf("v%0d_post_done", v), done, 0);
         check($sformatf("v%0d_post_write", v), reg_write, 0);
         check($sformatf("v%0d_post_op", v), alu_op, 0);
         check($sformatf("v%0d_hold_data", v), wr_data, vecs[v].e_wd);
         check($sformatf("v%0d_hold_addr", v), wr_addr, vecs[v].e_wa);
         check($sformatf("v%0d_zero_q", v), zero_q, vecs[v].e_zq);
         check($sformatf("v%0d_ovf_sticky", v), ovf_sticky, vecs[v].e_ovs);
      end

      // back-to-back issue with instr_valid held high
      alu_result = 8'h10;
      rdy_bits   = '0;
      done_bits  = '0;
      wa_first   = '0;
      wa_second  = '0;
      op_b       = '0;
      imm_b      = '0;
      acc        = 0;
      @(posedge clk);
      #1;
      instr       = mk(3'd3, 1'b0, 1'b0, 2'd1, 2'd2, 7'h05);
      instr_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rdy_s        = instr_ready;
         rdy_bits[c]  = instr_ready;
         done_bits[c] = done;
         if (c == 3) wa_first = wr_addr;
         if (c == 7) wa_second = wr_addr;
         if (c == 5) begin
            op_b  = alu_op;
            imm_b = instr_i;
         end
         @(posedge clk);
         if (rdy_s) acc++;
         #1;
         if (acc == 1) instr = mk(3'd4, 1'b1, 1'b0, 2'd3, 2'd0, 7'h10);
         if (acc == 2) instr_valid = 1'b0;
      end
      check("b2b_ready_pattern", rdy_bits, 8'b0001_0001);
      check("b2b_done_pattern", done_bits, 8'b1000_1000);
      check("b2b_wr_addr_a", wa_first, 2'd1);
      check("b2b_wr_addr_b", wa_second, 2'd3);
      check("b2b_op_b", op_b, 3'd4);
      check("b2b_instr_i_b", imm_b, 9'h010);

      // reset asserted in the middle of write-back
      @(negedge clk);
      instr       = mk(3'd6, 1'b0, 1'b0, 2'd2, 2'd1, 7'h01);
      instr_valid = 1'b1;
      alu_result  = 8'h55;
      alu_ovf     = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rstwb_pre_write", reg_write, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rstwb_write", reg_write, 0);
      check("rstwb_ready", instr_ready, 1);
      check("rstwb_done", done, 0);
      check("rstwb_ovf_cleared", ovf_sticky, 0);
      check("rstwb_wr_data", wr_data, 0);
      alu_ovf = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (reg_write || done) seen = 1'b1;
      end
      check("rstwb_no_late_write", seen, 0);
      check("rstwb_idle_ready", instr_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
